// File: rtl/spi_apb_req_arbiter.sv
// Round-robin front-end that lets two clients share one APB master port to the SPI register slave.
// Optional ACCESS-phase timeout is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_apb_req_arbiter #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic              req0_done_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  output logic              req0_err_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              req1_done_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic              req1_err_o,
  output logic              PSEL_o,
  output logic              PENABLE_o,
  output logic              PWRITE_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  input  logic [DATA_W-1:0] PRDATA_i,
  input  logic              PREADY_i,
  input  logic              PSLVERR_i,
  output logic              busy_o
);

  // Handshake: a command is taken in the cycle where valid and ready are both high at the
  // rising edge; ready is only ever high in IDLE and only for the arbitration winner.

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("spi_apb_req_arbiter: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic ptr;       // 1: req1 favoured on a tie
  logic gnt;       // requester owning the transfer in flight
  logic win_id;
  logic accept;
  logic xfer_ok;
  logic abort;
  logic finish;
  logic fin_err;

  always_comb begin
    win_id = 1'b0;
    if (req0_valid_i && req1_valid_i) win_id = ptr;
    else                              win_id = req1_valid_i;
  end

  assign accept       = (state == IDLE) && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = accept && !win_id;
  assign req1_ready_o = accept &&  win_id;

  assign xfer_ok = (state == ACCESS) && PREADY_i;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  assign abort = (state == ACCESS) && !PREADY_i && (wait_cnt == CNT_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY_i && !abort) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign finish  = xfer_ok || abort;
  assign fin_err = xfer_ok ? PSLVERR_i : 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  assign PSEL_o    = (state == SETUP) || (state == ACCESS);
  assign PENABLE_o = (state == ACCESS);
  assign busy_o    = (state != IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      PWRITE_o <= 1'b0;
      PADDR_o  <= '0;
      PWDATA_o <= '0;
    end else if (accept) begin
      ptr      <= !win_id;
      gnt      <= win_id;
      PWRITE_o <= win_id ? req1_write_i : req0_write_i;
      PADDR_o  <= win_id ? req1_addr_i  : req0_addr_i;
      PWDATA_o <= win_id ? req1_wdata_i : req0_wdata_i;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      req0_done_o  <= 1'b0;
      req1_done_o  <= 1'b0;
      req0_err_o   <= 1'b0;
      req1_err_o   <= 1'b0;
      req0_rdata_o <= '0;
      req1_rdata_o <= '0;
    end else begin
      req0_done_o <= finish && !gnt;
      req1_done_o <= finish &&  gnt;
      if (finish && !gnt) req0_err_o <= fin_err;
      if (finish &&  gnt) req1_err_o <= fin_err;
      // Read data is taken even on a slave error, never on a timeout abort.
      if (xfer_ok && !PWRITE_o && !gnt) req0_rdata_o <= PRDATA_i;
      if (xfer_ok && !PWRITE_o &&  gnt) req1_rdata_o <= PRDATA_i;
    end
  end

endmodule

// File: tb/tb_spi_apb_req_arbiter.sv
// Directed bench for spi_apb_req_arbiter: transfer timing, wait states, round-robin order,
// slave error, ACCESS timeout (macro-dependent) and asynchronous reset mid-transfer.
module tb_spi_apb_req_arbiter;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req0_valid_i, req0_write_i, req1_valid_i, req1_write_i;
  logic [2:0] req0_addr_i, req1_addr_i;
  logic [7:0] req0_wdata_i, req1_wdata_i;
  logic       req0_ready_o, req0_done_o, req0_err_o;
  logic       req1_ready_o, req1_done_o, req1_err_o;
  logic [7:0] req0_rdata_o, req1_rdata_o;
  logic       PSEL_o, PENABLE_o, PWRITE_o;
  logic [2:0] PADDR_o;
  logic [7:0] PWDATA_o, PRDATA_i;
  logic       PREADY_i, PSLVERR_i, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  spi_apb_req_arbiter #(.ADDR_W(3), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid_i(req0_valid_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
    .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o), .req0_done_o(req0_done_o),
    .req0_rdata_o(req0_rdata_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
    .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o), .req1_done_o(req1_done_o),
    .req1_rdata_o(req1_rdata_o), .req1_err_o(req1_err_o),
    .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o),
    .PWDATA_o(PWDATA_o), .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i),
    .busy_o(busy_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic mid;
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int got;
    int done_seen;
    logic [3:0] exp_order;

    PRESET = 1'b1;
    req0_valid_i = 0; req0_write_i = 0; req0_addr_i = 0; req0_wdata_i = 0;
    req1_valid_i = 0; req1_write_i = 0; req1_addr_i = 0; req1_wdata_i = 0;
    PRDATA_i = 0; PREADY_i = 0; PSLVERR_i = 0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset state
    mid;
    chk("rst_busy", busy_o, 0);
    chk("rst_psel", PSEL_o, 0);
    chk("rst_pen", PENABLE_o, 0);
    chk("rst_paddr", PADDR_o, 0);
    chk("rst_done", {req1_done_o, req0_done_o}, 0);
    chk("rst_rdata0", req0_rdata_o, 0);
    chk("rst_rdata1", req1_rdata_o, 0);

    // 1: req0 write addr 0 data AA, zero wait
    tick;
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 3'd0; req0_wdata_i = 8'hAA; PREADY_i = 1;
    mid;
    chk("t1_ready0", req0_ready_o, 1);
    chk("t1_ready1", req1_ready_o, 0);
    tick;
    req0_valid_i = 0; req0_wdata_i = 8'h55;
    mid;
    chk("t1_setup_psel", PSEL_o, 1);
    chk("t1_setup_pen", PENABLE_o, 0);
    chk("t1_pwrite", PWRITE_o, 1);
    chk("t1_paddr", PADDR_o, 0);
    chk("t1_pwdata", PWDATA_o, 8'hAA);
    chk("t1_ready_setup", req0_ready_o, 0);
    tick; mid;
    chk("t1_access_pen", PENABLE_o, 1);
    chk("t1_access_pwdata", PWDATA_o, 8'hAA);
    chk("t1_no_early_done", req0_done_o, 0);
    tick; mid;
    chk("t1_done", req0_done_o, 1);
    chk("t1_err", req0_err_o, 0);
    chk("t1_idle_psel", PSEL_o, 0);
    chk("t1_busy", busy_o, 0);
    tick; mid;
    chk("t1_done_pulse", req0_done_o, 0);

    // 2: req1 read addr 1, two wait states, PRDATA CC
    tick;
    req1_valid_i = 1; req1_write_i = 0; req1_addr_i = 3'd1; PREADY_i = 0; PRDATA_i = 8'hCC;
    mid;
    chk("t2_ready1", req1_ready_o, 1);
    tick;
    req1_valid_i = 0;
    mid;
    chk("t2_paddr", PADDR_o, 1);
    chk("t2_pwrite", PWRITE_o, 0);
    tick; mid; chk("t2_pen_w1", PENABLE_o, 1);
    tick; mid; chk("t2_pen_w2", PENABLE_o, 1);
    tick; PREADY_i = 1;
    mid;
    chk("t2_pen_last", PENABLE_o, 1);
    chk("t2_no_early_done", req1_done_o, 0);
    tick; PREADY_i = 0;
    mid;
    chk("t2_done1", req1_done_o, 1);
    chk("t2_done0", req0_done_o, 0);
    chk("t2_rdata1", req1_rdata_o, 8'hCC);
    chk("t2_rdata0", req0_rdata_o, 0);
    chk("t2_err1", req1_err_o, 0);

    // 3: both valid held, four transfers -> 0,1,0,1
    tick;
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 3'd6; req0_wdata_i = 8'h11;
    req1_valid_i = 1; req1_write_i = 1; req1_addr_i = 3'd7; req1_wdata_i = 8'h22;
    PREADY_i = 1;
    exp_order = 4'b1010;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      mid;
      if (req0_done_o || req1_done_o) begin
        chk($sformatf("t3_grant%0d", got), req1_done_o, exp_order[got]);
        got++;
        if (got == 4) begin
          req0_valid_i = 0;
          req1_valid_i = 0;
        end
      end
      tick;
    end
    chk("t3_count", got, 4);
    mid;
    chk("t3_idle", busy_o, 0);

    PRESET = 1; tick; PRESET = 0;
    req1_valid_i = 1; req1_write_i = 1; req1_addr_i = 3'd2;
    mid;
    chk("t3_rst_ready1", req1_ready_o, 1);
    chk("t3_rst_ready0", req0_ready_o, 0);
    tick; req1_valid_i = 0;
    tick; tick; mid;
    chk("t3_rst_done1", req1_done_o, 1);

    // 4: req0 read addr 2 with slave error, then a clean write
    tick;
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 3'd2; PRDATA_i = 8'hFF; PSLVERR_i = 1;
    mid;
    chk("t4_ready0", req0_ready_o, 1);
    tick; req0_valid_i = 0;
    tick; tick; mid;
    chk("t4_done0", req0_done_o, 1);
    chk("t4_err0", req0_err_o, 1);
    chk("t4_rdata0", req0_rdata_o, 8'hFF);
    chk("t4_rdata1", req1_rdata_o, 0);
    chk("t4_err1", req1_err_o, 0);
    tick;
    PSLVERR_i = 0; PRDATA_i = 8'h3C;
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 3'd3; req0_wdata_i = 8'h12;
    tick; req0_valid_i = 0;
    tick; tick; mid;
    chk("t4_next_done", req0_done_o, 1);
    chk("t4_next_err", req0_err_o, 0);
    chk("t4_write_keeps_rdata", req0_rdata_o, 8'hFF);

    // 5: PREADY stuck low
    tick;
    req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 3'd4; PREADY_i = 0; PRDATA_i = 8'h77;
    tick; req0_valid_i = 0;
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (16) tick;
    mid;
    chk("t5_no_early_abort", req0_done_o, 0);
    tick; mid;
    chk("t5_abort_done", req0_done_o, 1);
    chk("t5_abort_err", req0_err_o, 1);
    chk("t5_abort_rdata", req0_rdata_o, 8'hFF);
    chk("t5_abort_idle", busy_o, 0);
`else
    done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      mid;
      if (req0_done_o || req1_done_o) done_seen = 1;
      tick;
    end
    mid;
    chk("t5_still_busy", busy_o, 1);
    chk("t5_still_pen", PENABLE_o, 1);
    chk("t5_no_done", done_seen, 0);
    PRESET = 1; tick; PRESET = 0;
`endif

    // 6: async reset during ACCESS
    tick;
    req1_valid_i = 1; req1_write_i = 0; req1_addr_i = 3'd5; PREADY_i = 0; PRDATA_i = 8'h99;
    tick; req1_valid_i = 0;
    tick; mid;
    chk("t6_in_access", PENABLE_o, 1);
    PRESET = 1;
    #1;
    chk("t6_async_psel", PSEL_o, 0);
    chk("t6_async_pen", PENABLE_o, 0);
    chk("t6_async_busy", busy_o, 0);
    PREADY_i = 1;
    tick;
    PRESET = 0;
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 3'd1;
    req1_valid_i = 1; req1_write_i = 1; req1_addr_i = 3'd2;
    mid;
    chk("t6_no_done1", req1_done_o, 0);
    chk("t6_prio_ready0", req0_ready_o, 1);
    chk("t6_prio_ready1", req1_ready_o, 0);
    chk("t6_rdata1", req1_rdata_o, 0);
    tick;
    req0_valid_i = 0; req1_valid_i = 0;
    tick; tick; mid;
    chk("t6_done0", req0_done_o, 1);
    chk("t6_done1_quiet", req1_done_o, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
